// File: rtl/rect_pkg.sv
// Shared definitions for the rect_stream rectifier.
//   rect_mode_t : 2-bit per-sample rectification mode.
package rect_pkg;

    typedef enum logic [1:0] {
        RECT_FULL     = 2'd0,  // |x|
        RECT_HALF_POS = 2'd1,  // x if x >= 0, else 0
        RECT_HALF_NEG = 2'd2,  // -x if x < 0, else 0
        RECT_PASS     = 2'd3   // raw bit pattern
    } rect_mode_t;

endpackage

// File: rtl/rect_lane.sv
// Combinational rectifier for one signed sample.
//   data   : signed two's-complement sample
//   mode   : rectification mode
//   result : unsigned rectified magnitude (raw pattern in PASS)
//   sat    : result was clipped from the most-negative input
module rect_lane
    import rect_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] data,
    input  rect_mode_t   mode,
    output logic [N-1:0] result,
    output logic         sat
);

    localparam logic [N-1:0] MinNeg = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] MaxPos = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] One    = {{(N-1){1'b0}}, 1'b1};

    logic         neg;
    logic         is_min;
    logic [N-1:0] mag;

    always_comb begin
        neg    = data[N-1];
        is_min = (data == MinNeg);
        // -(-2^(N-1)) is not representable, so clip it to the largest magnitude
        mag    = neg ? (is_min ? MaxPos : (~data + One)) : data;
        result = '0;
        sat    = 1'b0;
        unique case (mode)
            RECT_FULL: begin
                result = mag;
                sat    = is_min;
            end
            RECT_HALF_POS: begin
                result = neg ? '0 : data;
            end
            RECT_HALF_NEG: begin
                result = neg ? mag : '0;
                sat    = is_min;
            end
            RECT_PASS: begin
                result = data;
            end
        endcase
    end

endmodule

// File: rtl/rect_stream.sv
// Two-stage streaming rectifier with valid/ready on both sides and
// per-channel saturating negative-sample counters.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_data     : input sample handshake, signed data
//   in_ch, mode                   : channel tag and mode, captured with the sample
//   out_valid/out_ready/out_data  : output handshake, unsigned result
//   out_ch, out_sat               : tag and clip flag travelling with the result
//   cnt_sel, cnt_clr, cnt_out     : counter select, clear pulse, registered readback
module rect_stream
    import rect_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned CH    = 4,
    parameter int unsigned CW    = 16,
    localparam int unsigned CW_CH = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic [CW_CH-1:0] in_ch,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [CW_CH-1:0] out_ch,
    output logic             out_sat,
    input  logic [CW_CH-1:0] cnt_sel,
    input  logic             cnt_clr,
    output logic [CW-1:0]    cnt_out
);

    localparam logic [CW-1:0] CntOne = {{(CW-1){1'b0}}, 1'b1};

    function automatic logic [CW_CH-1:0] clamp_ch(input logic [CW_CH-1:0] c);
        return (32'(c) >= CH) ? CW_CH'(CH - 1) : c;
    endfunction

    logic             s1_valid, s2_valid;
    logic [N-1:0]     s1_data, s2_data;
    logic [CW_CH-1:0] s1_ch, s2_ch;
    rect_mode_t       s1_mode;
    logic             s2_sat;

    logic             s1_adv, s2_adv, accept;
    logic [CW_CH-1:0] in_ch_eff, sel_eff;
    logic [N-1:0]     lane_result;
    logic             lane_sat;

    logic [CW-1:0]    cnt_q [CH];
    logic [CW-1:0]    cnt_d [CH];

    rect_lane #(
        .N(N)
    ) u_lane (
        .data  (s1_data),
        .mode  (s1_mode),
        .result(lane_result),
        .sat   (lane_sat)
    );

    always_comb begin
        s2_adv    = !s2_valid || out_ready;
        s1_adv    = !s1_valid || s2_adv;
        in_ready  = !rst && s1_adv;
        accept    = in_valid && in_ready;
        in_ch_eff = clamp_ch(in_ch);
        sel_eff   = clamp_ch(cnt_sel);
    end

    // Clear wins over the old value, but a same-cycle increment still lands on top of it.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr && (sel_eff == CW_CH'(i))) begin
                cnt_d[i] = (accept && in_data[N-1] && (in_ch_eff == CW_CH'(i))) ? CntOne : '0;
            end else if (accept && in_data[N-1] && (in_ch_eff == CW_CH'(i))
                         && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_data  <= '0;
            s1_ch    <= '0;
            s1_mode  <= RECT_FULL;
            s2_data  <= '0;
            s2_ch    <= '0;
            s2_sat   <= 1'b0;
            cnt_out  <= '0;
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (s1_adv) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_data <= in_data;
                    s1_ch   <= in_ch_eff;
                    s1_mode <= rect_mode_t'(mode);
                end
            end
            // S2 only reloads while not stalled, so outputs hold under backpressure
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= lane_result;
                    s2_ch   <= s1_ch;
                    s2_sat  <= lane_sat;
                end
            end
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            cnt_out <= cnt_q[sel_eff];
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_ch    = s2_ch;
    assign out_sat   = s2_sat;

endmodule
